// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be
// Simple dual-port RAM with one write port and one read port on a common clock.
// Per-byte write enables, read latency of 1 or 2 edges, selectable
// read-during-write result, out-of-range read flagging and an optional
// zero-fill sweep after reset.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   init_busy  high while the zero-fill sweep runs; both ports ignored
//   wr_en      write request
//   wr_addr    write address (>= DEPTH is dropped)
//   wr_be      byte enables, bit i selects wr_data[8i+7:8i]
//   wr_data    write data
//   rd_en      read request
//   rd_addr    read address
//   rd_data    read data, holds its value while rd_valid is low
//   rd_valid   one-cycle pulse per accepted read
//   rd_err     qualifies rd_valid: read address was >= DEPTH (rd_data = 0)
module dual_port_ram_be #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_SIZE     = 4,
  parameter int DEPTH         = 16,
  parameter int RD_LATENCY    = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [ADDR_SIZE-1:0]    wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_SIZE-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_err
);

  localparam int BE_W = DATA_WIDTH / 8;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;
  localparam logic [0:0] RESET_STATE = (INIT_ON_RESET != 0) ? CLEAR : IDLE;

  // One extra bit so DEPTH == 2**ADDR_SIZE is still representable.
  localparam logic [ADDR_SIZE:0]   DEPTH_X   = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       be
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
    end
    return w;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_SIZE-1:0]  cnt;

  logic                  wr_ok_p0;
  logic                  vld_p0;
  logic                  err_p0;
  logic [DATA_WIDTH-1:0] old_p0;
  logic [DATA_WIDTH-1:0] word_p0;

  logic                  vld_out;
  logic                  err_out;
  logic [DATA_WIDTH-1:0] word_out;

  assign init_busy = (state == CLEAR);
  assign wr_ok_p0  = wr_en && !init_busy && ({1'b0, wr_addr} < DEPTH_X);
  assign vld_p0    = rd_en && !init_busy;
  assign err_p0    = ({1'b0, rd_addr} >= DEPTH_X);

  // Zero-fill sweep: one word per edge, then idle until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      if (cnt == LAST_ADDR) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Storage is never reset; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[cnt] <= '0;
    end else if (wr_ok_p0) begin
      mem[wr_addr] <= merge_bytes(mem[wr_addr], wr_data, wr_be);
    end
  end

  // ---- stage p0: array lookup and same-address bypass ----
  // The array read is the pre-edge contents, i.e. old data; the merged word
  // is substituted only when new-data read-during-write is selected.
  always_comb begin
    old_p0  = '0;
    word_p0 = '0;
    if (!err_p0) begin
      old_p0  = mem[rd_addr];
      word_p0 = old_p0;
      if (RDW_MODE != 0 && wr_ok_p0 && wr_addr == rd_addr) begin
        word_p0 = merge_bytes(old_p0, wr_data, wr_be);
      end
    end
  end

  // ---- stage p1: optional extra register for two-edge latency ----
  if (RD_LATENCY == 2) begin : g_lat2
    logic                  vld_p1;
    logic                  err_p1;
    logic [DATA_WIDTH-1:0] word_p1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p1  <= 1'b0;
        err_p1  <= 1'b0;
        word_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        err_p1 <= err_p0;
        if (vld_p0) word_p1 <= word_p0;
      end
    end

    assign vld_out  = vld_p1;
    assign err_out  = err_p1;
    assign word_out = word_p1;
  end else begin : g_lat1
    assign vld_out  = vld_p0;
    assign err_out  = err_p0;
    assign word_out = word_p0;
  end

  // ---- output stage: rd_data only moves on a valid read ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= vld_out;
      rd_err   <= vld_out && err_out;
      if (vld_out) rd_data <= word_out;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be. Two instances share one set of inputs:
//   dut_a: DEPTH=16, RD_LATENCY=1, RDW_MODE=0
//   dut_b: DEPTH=12, RD_LATENCY=2, RDW_MODE=1
// A behavioural model (plain word arrays plus a record of each read request's
// result, emitted RD_LATENCY-1 edges later) predicts both instances.
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        busy_a, rvld_a, rerr_a;
  logic [31:0] rdata_a;
  logic        busy_b, rvld_b, rerr_b;
  logic [31:0] rdata_b;

  dual_port_ram_be #(
    .DATA_WIDTH(32), .ADDR_SIZE(4), .DEPTH(16),
    .RD_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst(rst), .init_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata_a), .rd_valid(rvld_a), .rd_err(rerr_a)
  );

  dual_port_ram_be #(
    .DATA_WIDTH(32), .ADDR_SIZE(4), .DEPTH(12),
    .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst(rst), .init_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata_b), .rd_valid(rvld_b), .rd_err(rerr_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] m  [2][16];
  int          left [2];
  logic        hv [2][4];
  logic        he [2][4];
  logic [31:0] hd [2][4];
  logic        ev [2];
  logic        ee [2];
  logic [31:0] ed [2];
  int          ecnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic int dep_of(int k); return (k == 0) ? 16 : 12; endfunction
  function automatic int lat_of(int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int rdw_of(int k); return (k == 0) ? 0 : 1; endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
    return w;
  endfunction

  // {init_busy, rd_valid, rd_err, rd_data}
  function automatic logic [34:0] exp_vec(int k);
    return {(left[k] > 0), ev[k], ee[k], ed[k]};
  endfunction

  function automatic logic [34:0] obs_vec(int k);
    return (k == 0) ? {busy_a, rvld_a, rerr_a, rdata_a} : {busy_b, rvld_b, rerr_b, rdata_b};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k] = dep_of(k);
      for (int i = 0; i < 4; i++) begin
        hv[k][i] = 1'b0; he[k][i] = 1'b0; hd[k][i] = '0;
      end
      ev[k] = 1'b0; ee[k] = 1'b0; ed[k] = '0;
    end
  endtask

  // Advance one rising edge, apply the spec rules to the model, then settle.
  task automatic step();
    int s, dep, lat;
    logic oob, hit;
    logic [31:0] old_w;
    @(posedge clk);
    ecnt++;
    for (int k = 0; k < 2; k++) begin
      dep = dep_of(k);
      lat = lat_of(k);
      s = ecnt & 3;
      hv[k][s] = 1'b0; he[k][s] = 1'b0; hd[k][s] = '0;
      if (rst) begin
        ev[k] = 1'b0; ee[k] = 1'b0; ed[k] = '0;
      end else begin
        if (left[k] > 0) begin
          m[k][dep - left[k]] = '0;
          left[k]--;
        end else begin
          oob = int'(rd_addr) >= dep;
          hit = wr_en && (int'(wr_addr) < dep);
          if (rd_en) begin
            hv[k][s] = 1'b1;
            he[k][s] = oob;
            if (!oob) begin
              old_w = m[k][rd_addr];
              hd[k][s] = (rdw_of(k) == 1 && hit && wr_addr == rd_addr)
                         ? merge(old_w, wr_data, wr_be) : old_w;
            end
          end
          if (hit) m[k][wr_addr] = merge(m[k][wr_addr], wr_data, wr_be);
        end
        s = (ecnt - (lat - 1)) & 3;
        ev[k] = hv[k][s];
        ee[k] = hv[k][s] ? he[k][s] : 1'b0;
        if (hv[k][s]) ed[k] = hd[k][s];
      end
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic set_wr(input logic en, input logic [3:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    wr_en = en; wr_addr = a; wr_be = be; wr_data = d;
  endtask

  task automatic set_rd(input logic en, input logic [3:0] a);
    rd_en = en; rd_addr = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    #2 rst = 1'b1;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obs_vec(k) !== {1'b1, 1'b0, 1'b0, 32'h0})
        $display("FAIL reset_async dut%0d got %h required %h", k, obs_vec(k), {1'b1, 1'b0, 1'b0, 32'h0});
      else n_pass++;
    end
    repeat (2) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL reset_hold dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    int cnt_a, cnt_b;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      cnt_a += int'(busy_a);
      cnt_b += int'(busy_b);
      set_wr((i < 12) ? 1'($urandom) : 1'b0, 4'($urandom), 4'($urandom), $urandom);
      set_rd(1'($urandom), 4'($urandom));
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL sweep dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    idle();
    n_total++;
    if (cnt_a !== 16) $display("FAIL sweep_len_a got %0d required 16", cnt_a); else n_pass++;
    n_total++;
    if (cnt_b !== 12) $display("FAIL sweep_len_b got %0d required 12", cnt_b); else n_pass++;
    for (int i = 0; i < 18; i++) begin
      set_rd(i < 16, 4'(i));
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL sweep_readback dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_byte_enable();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 0) set_wr(1'b1, 4'd5, 4'hF, 32'hAABBCCDD);
      if (i == 1) set_wr(1'b1, 4'd5, 4'b0101, 32'h11223344);
      if (i == 2) set_rd(1'b1, 4'd5);
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL byte_en dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
      if (i == 2) begin
        n_total++;
        if (obs_vec(0) !== {1'b0, 1'b1, 1'b0, 32'hAA22CC44})
          $display("FAIL byte_en_a got %h required %h", obs_vec(0), {1'b0, 1'b1, 1'b0, 32'hAA22CC44});
        else n_pass++;
      end
      if (i == 3) begin
        n_total++;
        if (obs_vec(1) !== {1'b0, 1'b1, 1'b0, 32'hAA22CC44})
          $display("FAIL byte_en_b got %h required %h", obs_vec(1), {1'b0, 1'b1, 1'b0, 32'hAA22CC44});
        else n_pass++;
        n_total++;
        if (obs_vec(0) !== {1'b0, 1'b0, 1'b0, 32'hAA22CC44})
          $display("FAIL byte_en_hold_a got %h required %h", obs_vec(0), {1'b0, 1'b0, 1'b0, 32'hAA22CC44});
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_rdw();
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) set_wr(1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
      if (i == 1) begin
        set_wr(1'b1, 4'd3, 4'hF, 32'h12345678);
        set_rd(1'b1, 4'd3);
      end
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL rdw dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
      if (i == 1) begin
        n_total++;
        if (obs_vec(0) !== {1'b0, 1'b1, 1'b0, 32'hDEADBEEF})
          $display("FAIL rdw_old_a got %h required %h", obs_vec(0), {1'b0, 1'b1, 1'b0, 32'hDEADBEEF});
        else n_pass++;
      end
      if (i == 2) begin
        n_total++;
        if (obs_vec(1) !== {1'b0, 1'b1, 1'b0, 32'h12345678})
          $display("FAIL rdw_new_b got %h required %h", obs_vec(1), {1'b0, 1'b1, 1'b0, 32'h12345678});
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 0) set_wr(1'b1, 4'd13, 4'hF, 32'hFFFFFFFF);
      if (i == 1) set_rd(1'b1, 4'd13);
      if (i == 2) set_rd(1'b1, 4'd0);
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL oob dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
      if (i == 1) begin
        n_total++;
        if (obs_vec(0) !== {1'b0, 1'b1, 1'b0, 32'hFFFFFFFF})
          $display("FAIL oob_inrange_a got %h required %h", obs_vec(0), {1'b0, 1'b1, 1'b0, 32'hFFFFFFFF});
        else n_pass++;
      end
      if (i == 2) begin
        n_total++;
        if (obs_vec(1) !== {1'b0, 1'b1, 1'b1, 32'h0})
          $display("FAIL oob_err_b got %h required %h", obs_vec(1), {1'b0, 1'b1, 1'b1, 32'h0});
        else n_pass++;
      end
      if (i == 3) begin
        n_total++;
        if (obs_vec(1) !== {1'b0, 1'b1, 1'b0, 32'h0})
          $display("FAIL oob_addr0_b got %h required %h", obs_vec(1), {1'b0, 1'b1, 1'b0, 32'h0});
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    for (int i = 0; i < 3; i++) vals[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 3) set_wr(1'b1, 4'(i + 1), 4'hF, vals[i]);
      if (i >= 3 && i < 6) set_rd(1'b1, 4'(i - 2));
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL b2b dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
      // dut_b returns the three words on the three edges after each request
      if (i >= 4 && i < 7) begin
        n_total++;
        if (obs_vec(1) !== {1'b0, 1'b1, 1'b0, vals[i - 4]})
          $display("FAIL b2b_order_b edge %0d got %h required %h", ecnt, obs_vec(1), {1'b0, 1'b1, 1'b0, vals[i - 4]});
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_wr(1'($urandom), 4'($urandom), 4'($urandom), $urandom);
      set_rd(1'($urandom), 4'($urandom));
      // bias some edges towards same-address read and write
      if (($urandom & 3) == 0) rd_addr = wr_addr;
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL random dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    idle();
    rst = 1'b1;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obs_vec(k) !== {1'b1, 1'b0, 1'b0, 32'h0})
        $display("FAIL reset_clear dut%0d got %h required %h", k, obs_vec(k), {1'b1, 1'b0, 1'b0, 32'h0});
      else n_pass++;
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_rd(1'($urandom), 4'($urandom));
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL mid_sweep dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    idle();
    rst = 1'b1;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obs_vec(k) !== {1'b1, 1'b0, 1'b0, 32'h0})
        $display("FAIL mid_reset dut%0d got %h required %h", k, obs_vec(k), {1'b1, 1'b0, 1'b0, 32'h0});
      else n_pass++;
    end
    step();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && busy_a; i++) begin
      cnt++;
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL restart dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    n_total++;
    if (cnt !== 16) $display("FAIL restart_len got %0d required 16", cnt); else n_pass++;
    for (int i = 0; i < 18; i++) begin
      set_rd(i < 16, 4'(i));
      step();
      for (int k = 0; k < 2; k++) begin
        n_total++;
        if (obs_vec(k) !== exp_vec(k))
          $display("FAIL restart_readback dut%0d edge %0d got %h required %h", k, ecnt, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
